// File: rtl/ai_layer_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : ai_layer_sched_if
// Description : Memory read/write burst and compute-engine handshake bundle
//               between the layer scheduler (master) and the datapath (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface ai_layer_sched_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
);
  logic              rd_req;
  logic              rd_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              mem_read_done;
  logic              compute_start;
  logic              compute_done;
  logic              wr_req;
  logic              wr_ack;
  logic [ADDR_W-1:0] wr_addr;
  logic [LEN_W-1:0]  wr_len;
  logic              mem_write_done;

  modport master (
    output rd_req, rd_addr, rd_len, compute_start, wr_req, wr_addr, wr_len,
    input  rd_ack, mem_read_done, compute_done, wr_ack, mem_write_done
  );

  modport slave (
    input  rd_req, rd_addr, rd_len, compute_start, wr_req, wr_addr, wr_len,
    output rd_ack, mem_read_done, compute_done, wr_ack, mem_write_done
  );
endinterface
`default_nettype wire

// File: rtl/ai_layer_sched.sv
`default_nettype none
// ============================================================================
// Module      : ai_layer_sched
// Description : Per-layer output-row scheduler: read window, compute, write
//               back, one output row at a time. Optional macro
//               AI_SCHED_PERF_EN enables the perf_cycles layer cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ai_layer_sched #(
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 16,
  parameter int DIM_W   = 8,
  parameter int K_WIDTH = 4,
  parameter int S_WIDTH = 4
) (
  input  wire                 clk,
  input  wire                 rst,
  input  wire                 start_decoded,
  input  wire [K_WIDTH-1:0]   kernel_size,
  input  wire [S_WIDTH-1:0]   stride,
  input  wire [DIM_W-1:0]     ifm_rows,
  input  wire [DIM_W-1:0]     ifm_cols,
  input  wire [ADDR_W-1:0]    ifm_base,
  input  wire [ADDR_W-1:0]    ofm_base,
  output logic                busy,
  ai_layer_sched_if.master    bus,
  output logic                seq_done,
  output logic                err_cfg,
  output logic [31:0]         perf_cycles
);

  localparam int CMP_W  = DIM_W + 1;
  localparam int OFF_W  = 2 * DIM_W;
  localparam int PROD_W = K_WIDTH + DIM_W;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CHECK   = 4'd1;
  localparam logic [3:0] S_CALC    = 4'd2;
  localparam logic [3:0] S_RD_REQ  = 4'd3;
  localparam logic [3:0] S_RD_WAIT = 4'd4;
  localparam logic [3:0] S_COMP    = 4'd5;
  localparam logic [3:0] S_WR_REQ  = 4'd6;
  localparam logic [3:0] S_WR_WAIT = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  logic [3:0]         state_q, state_d;
  logic [K_WIDTH-1:0] kernel_q, kernel_d;
  logic [S_WIDTH-1:0] stride_q, stride_d;
  logic [DIM_W-1:0]   rows_q, rows_d;
  logic [DIM_W-1:0]   cols_q, cols_d;
  logic [ADDR_W-1:0]  ifm_base_q, ifm_base_d;
  logic [ADDR_W-1:0]  ofm_base_q, ofm_base_d;
  logic [CMP_W-1:0]   pos_q, pos_d;
  logic [DIM_W-1:0]   out_cols_q, out_cols_d;
  logic [DIM_W-1:0]   in_row_q, in_row_d;
  logic [DIM_W-1:0]   out_row_q, out_row_d;
  logic               err_cfg_q, err_cfg_d;
  logic               compute_start_q, compute_start_d;

  logic               cfg_bad;
  logic               calc_fit;
  logic               last_row;
  logic [OFF_W-1:0]   rd_off;
  logic [OFF_W-1:0]   wr_off;
  logic [PROD_W-1:0]  rd_prod;

  // All boundary compares are done one bit wider than DIM_W so sums never wrap.
  assign cfg_bad  = (kernel_q == '0) || (stride_q == '0) ||
                    (CMP_W'(kernel_q) > CMP_W'(rows_q)) ||
                    (CMP_W'(kernel_q) > CMP_W'(cols_q));
  assign calc_fit = (pos_q + CMP_W'(kernel_q)) <= CMP_W'(cols_q);
  assign last_row = (CMP_W'(in_row_q) + CMP_W'(stride_q) + CMP_W'(kernel_q)) > CMP_W'(rows_q);

  assign rd_off  = OFF_W'(in_row_q) * OFF_W'(cols_q);
  assign wr_off  = OFF_W'(out_row_q) * OFF_W'(out_cols_q);
  assign rd_prod = PROD_W'(kernel_q) * PROD_W'(cols_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      kernel_q        <= '0;
      stride_q        <= '0;
      rows_q          <= '0;
      cols_q          <= '0;
      ifm_base_q      <= '0;
      ofm_base_q      <= '0;
      pos_q           <= '0;
      out_cols_q      <= '0;
      in_row_q        <= '0;
      out_row_q       <= '0;
      err_cfg_q       <= 1'b0;
      compute_start_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      kernel_q        <= kernel_d;
      stride_q        <= stride_d;
      rows_q          <= rows_d;
      cols_q          <= cols_d;
      ifm_base_q      <= ifm_base_d;
      ofm_base_q      <= ofm_base_d;
      pos_q           <= pos_d;
      out_cols_q      <= out_cols_d;
      in_row_q        <= in_row_d;
      out_row_q       <= out_row_d;
      err_cfg_q       <= err_cfg_d;
      compute_start_q <= compute_start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_decoded) state_d = S_CHECK;
      S_CHECK:   state_d = cfg_bad ? S_IDLE : S_CALC;
      S_CALC:    if (!calc_fit) state_d = S_RD_REQ;
      S_RD_REQ:  if (bus.rd_ack) state_d = S_RD_WAIT;
      S_RD_WAIT: if (bus.mem_read_done) state_d = S_COMP;
      S_COMP:    if (bus.compute_done) state_d = S_WR_REQ;
      S_WR_REQ:  if (bus.wr_ack) state_d = S_WR_WAIT;
      S_WR_WAIT: if (bus.mem_write_done) state_d = last_row ? S_DONE : S_RD_REQ;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    kernel_d        = kernel_q;
    stride_d        = stride_q;
    rows_d          = rows_q;
    cols_d          = cols_q;
    ifm_base_d      = ifm_base_q;
    ofm_base_d      = ofm_base_q;
    pos_d           = pos_q;
    out_cols_d      = out_cols_q;
    in_row_d        = in_row_q;
    out_row_d       = out_row_q;
    err_cfg_d       = 1'b0;
    compute_start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_decoded) begin
          kernel_d   = kernel_size;
          stride_d   = stride;
          rows_d     = ifm_rows;
          cols_d     = ifm_cols;
          ifm_base_d = ifm_base;
          ofm_base_d = ofm_base;
        end
      end
      S_CHECK: begin
        if (cfg_bad) begin
          err_cfg_d = 1'b1;
        end else begin
          pos_d      = '0;
          out_cols_d = '0;
        end
      end
      // Repeated subtraction in place of a divider: one output column per cycle.
      S_CALC: begin
        if (calc_fit) begin
          out_cols_d = out_cols_q + 1'b1;
          pos_d      = pos_q + CMP_W'(stride_q);
        end else begin
          in_row_d  = '0;
          out_row_d = '0;
        end
      end
      S_RD_WAIT: begin
        if (bus.mem_read_done) compute_start_d = 1'b1;
      end
      S_WR_WAIT: begin
        if (bus.mem_write_done && !last_row) begin
          in_row_d  = in_row_q + DIM_W'(stride_q);
          out_row_d = out_row_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy              = (state_q != S_IDLE);
    seq_done          = (state_q == S_DONE);
    err_cfg           = err_cfg_q;
    bus.compute_start = compute_start_q;
    bus.rd_req        = 1'b0;
    bus.rd_addr       = '0;
    bus.rd_len        = '0;
    bus.wr_req        = 1'b0;
    bus.wr_addr       = '0;
    bus.wr_len        = '0;
    if (state_q == S_RD_REQ) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = ifm_base_q + ADDR_W'(rd_off);
      bus.rd_len  = LEN_W'(rd_prod);
    end
    if (state_q == S_WR_REQ) begin
      bus.wr_req  = 1'b1;
      bus.wr_addr = ofm_base_q + ADDR_W'(wr_off);
      bus.wr_len  = LEN_W'(out_cols_q);
    end
  end

`ifdef AI_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Counts every busy cycle; IDLE holds the last value until a new start.
  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE) begin
      if (start_decoded) perf_d = '0;
    end else begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ai_layer_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ai_layer_sched
// Description : Directed self-checking bench for ai_layer_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ai_layer_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_decoded = 1'b0;
  logic [3:0]  kernel_size = '0;
  logic [3:0]  stride = '0;
  logic [7:0]  ifm_rows = '0;
  logic [7:0]  ifm_cols = '0;
  logic [31:0] ifm_base = '0;
  logic [31:0] ofm_base = '0;
  logic        busy;
  logic        seq_done;
  logic        err_cfg;
  logic [31:0] perf_cycles;

  ai_layer_sched_if bus ();

  ai_layer_sched dut (
    .clk           (clk),
    .rst           (rst),
    .start_decoded (start_decoded),
    .kernel_size   (kernel_size),
    .stride        (stride),
    .ifm_rows      (ifm_rows),
    .ifm_cols      (ifm_cols),
    .ifm_base      (ifm_base),
    .ofm_base      (ofm_base),
    .busy          (busy),
    .bus           (bus),
    .seq_done      (seq_done),
    .err_cfg       (err_cfg),
    .perf_cycles   (perf_cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] rd_addr_log [0:7];
  logic [15:0] rd_len_log  [0:7];
  logic [31:0] wr_addr_log [0:7];
  logic [15:0] wr_len_log  [0:7];
  int n_rd, n_wr, n_cs, n_seq, n_err, n_unstable;
  int seq_cyc, wd_cyc, err_cyc;
  bit timed_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_resp();
    bus.rd_ack         = 1'b0;
    bus.mem_read_done  = 1'b0;
    bus.compute_done   = 1'b0;
    bus.wr_ack         = 1'b0;
    bus.mem_write_done = 1'b0;
  endtask

  task automatic start_layer(input logic [3:0] k, input logic [3:0] s,
                             input logic [7:0] r, input logic [7:0] c);
    kernel_size   = k;
    stride        = s;
    ifm_rows      = r;
    ifm_cols      = c;
    ifm_base      = 32'h1000;
    ofm_base      = 32'h2000;
    start_decoded = 1'b1;
    tick();
    start_decoded = 1'b0;
  endtask

  // Reactive memory/compute model; cycle 0 is the first cycle after start.
  task automatic run_layer(input int rd_ack_delay, input int rd_done_delay,
                           input bit stray_wd, input bit stray_start, input int stop_cs);
    int rd_wait_cnt = 0;
    int rd_done_cnt = 0;
    bit pend_rd = 1'b0;
    bit pend_wr = 1'b0;
    logic [31:0] hold_addr = '0;
    logic [15:0] hold_len = '0;
    n_rd = 0; n_wr = 0; n_cs = 0; n_seq = 0; n_err = 0; n_unstable = 0;
    seq_cyc = -1; wd_cyc = -1; err_cyc = -1; timed_out = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      clear_resp();
      if (seq_done) begin n_seq++; seq_cyc = cyc; end
      if (err_cfg) begin n_err++; err_cyc = cyc; end
      if (!busy) begin
        start_decoded = 1'b0;
        return;
      end
      if (stray_start && cyc == 6) begin
        start_decoded = 1'b1;
        kernel_size   = 4'd1;
        ifm_cols      = 8'd9;
      end else begin
        start_decoded = 1'b0;
      end
      if (bus.compute_start) begin
        n_cs++;
        if (n_cs == stop_cs) return;
        bus.compute_done = 1'b1;
      end
      if (bus.rd_req) begin
        if (rd_wait_cnt == 0) begin
          hold_addr = bus.rd_addr;
          hold_len  = bus.rd_len;
        end else if (bus.rd_addr !== hold_addr || bus.rd_len !== hold_len) begin
          n_unstable++;
        end
        if (rd_wait_cnt >= rd_ack_delay) begin
          bus.rd_ack = 1'b1;
          if (n_rd < 8) begin
            rd_addr_log[n_rd] = bus.rd_addr;
            rd_len_log[n_rd]  = bus.rd_len;
          end
          n_rd++;
          rd_wait_cnt = 0;
          rd_done_cnt = 0;
          pend_rd = 1'b1;
        end else begin
          rd_wait_cnt++;
        end
      end else if (pend_rd) begin
        if (rd_done_cnt >= rd_done_delay) begin
          bus.mem_read_done = 1'b1;
          pend_rd = 1'b0;
        end else begin
          if (stray_wd) bus.mem_write_done = 1'b1;
          rd_done_cnt++;
        end
      end
      if (bus.wr_req) begin
        bus.wr_ack = 1'b1;
        if (n_wr < 8) begin
          wr_addr_log[n_wr] = bus.wr_addr;
          wr_len_log[n_wr]  = bus.wr_len;
        end
        n_wr++;
        pend_wr = 1'b1;
      end else if (pend_wr) begin
        bus.mem_write_done = 1'b1;
        pend_wr = 1'b0;
        wd_cyc = cyc;
      end
      tick();
    end
    clear_resp();
    timed_out = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_resp();
    repeat (3) tick();
    checks++;
    if ({busy, bus.rd_req, bus.wr_req, bus.compute_start, seq_done, err_cfg,
         bus.rd_addr, bus.rd_len, bus.wr_addr, bus.wr_len} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b rd_req=%b wr_req=%b cs=%b seq=%b err=%b, required all 0",
               busy, bus.rd_req, bus.wr_req, bus.compute_start, seq_done, err_cfg);
    end
    checks++;
    if (perf_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf: got %0d required 0", perf_cycles);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic check_4x4_run(input string tag);
    checks++;
    if (timed_out !== 1'b0 || n_rd != 2 || n_wr != 2 || n_cs != 2) begin
      errors++;
      $display("FAIL %s_counts: timeout=%0d rd=%0d wr=%0d cs=%0d, required 0/2/2/2",
               tag, timed_out, n_rd, n_wr, n_cs);
    end
    checks++;
    if (rd_addr_log[0] !== 32'h1000 || rd_addr_log[1] !== 32'h1004) begin
      errors++;
      $display("FAIL %s_rd_addr: got %h %h required 00001000 00001004",
               tag, rd_addr_log[0], rd_addr_log[1]);
    end
    checks++;
    if (rd_len_log[0] !== 16'd12 || rd_len_log[1] !== 16'd12) begin
      errors++;
      $display("FAIL %s_rd_len: got %0d %0d required 12 12", tag, rd_len_log[0], rd_len_log[1]);
    end
    checks++;
    if (wr_addr_log[0] !== 32'h2000 || wr_addr_log[1] !== 32'h2002) begin
      errors++;
      $display("FAIL %s_wr_addr: got %h %h required 00002000 00002002",
               tag, wr_addr_log[0], wr_addr_log[1]);
    end
    checks++;
    if (wr_len_log[0] !== 16'd2 || wr_len_log[1] !== 16'd2) begin
      errors++;
      $display("FAIL %s_wr_len: got %0d %0d required 2 2", tag, wr_len_log[0], wr_len_log[1]);
    end
    checks++;
    if (n_seq != 1 || seq_cyc != wd_cyc + 1) begin
      errors++;
      $display("FAIL %s_seq_done: pulses=%0d at cycle %0d, required 1 at cycle %0d",
               tag, n_seq, seq_cyc, wd_cyc + 1);
    end
  endtask

  task automatic test_basic_4x4();
    logic [31:0] exp_perf;
    start_layer(4'd3, 4'd1, 8'd4, 8'd4);
    run_layer(0, 0, 1'b0, 1'b0, 0);
    check_4x4_run("basic");
    checks++;
    if (seq_cyc != 14) begin
      errors++;
      $display("FAIL basic_latency: seq_done at cycle %0d required 14", seq_cyc);
    end
`ifdef AI_SCHED_PERF_EN
    exp_perf = 32'd15;
`else
    exp_perf = 32'd0;
`endif
    checks++;
    if (perf_cycles !== exp_perf) begin
      errors++;
      $display("FAIL perf_cycles: got %0d required %0d", perf_cycles, exp_perf);
    end
  endtask

  task automatic test_stride2_5x5();
    start_layer(4'd3, 4'd2, 8'd5, 8'd5);
    run_layer(0, 0, 1'b0, 1'b0, 0);
    checks++;
    if (timed_out !== 1'b0 || n_rd != 2 || n_wr != 2 || n_cs != 2 || n_seq != 1) begin
      errors++;
      $display("FAIL s2_counts: timeout=%0d rd=%0d wr=%0d cs=%0d seq=%0d, required 0/2/2/2/1",
               timed_out, n_rd, n_wr, n_cs, n_seq);
    end
    checks++;
    if (rd_addr_log[0] !== 32'h1000 || rd_addr_log[1] !== 32'h100A ||
        rd_len_log[0] !== 16'd15 || rd_len_log[1] !== 16'd15) begin
      errors++;
      $display("FAIL s2_rd: got %h/%0d %h/%0d required 00001000/15 0000100a/15",
               rd_addr_log[0], rd_len_log[0], rd_addr_log[1], rd_len_log[1]);
    end
    checks++;
    if (wr_addr_log[0] !== 32'h2000 || wr_addr_log[1] !== 32'h2002 ||
        wr_len_log[0] !== 16'd2 || wr_len_log[1] !== 16'd2) begin
      errors++;
      $display("FAIL s2_wr: got %h/%0d %h/%0d required 00002000/2 00002002/2",
               wr_addr_log[0], wr_len_log[0], wr_addr_log[1], wr_len_log[1]);
    end
  endtask

  task automatic test_bad_cfg(input logic [3:0] k, input string tag);
    start_layer(k, 4'd1, 8'd4, 8'd4);
    run_layer(0, 0, 1'b0, 1'b0, 0);
    checks++;
    if (n_err != 1 || err_cyc != 1 || n_rd != 0 || n_seq != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: err=%0d at %0d rd=%0d seq=%0d busy=%b, required 1 at 1, 0, 0, 0",
               tag, n_err, err_cyc, n_rd, n_seq, busy);
    end
    tick();
    checks++;
    if (err_cfg !== 1'b0 || bus.rd_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse: err_cfg=%b rd_req=%b one cycle later, required 0 0",
               tag, err_cfg, bus.rd_req);
    end
  endtask

  task automatic test_backpressure();
    start_layer(4'd3, 4'd1, 8'd4, 8'd4);
    run_layer(10, 3, 1'b1, 1'b1, 0);
    checks++;
    if (n_unstable != 0) begin
      errors++;
      $display("FAIL bp_rd_stable: %0d changes of rd_addr/rd_len while waiting, required 0", n_unstable);
    end
    check_4x4_run("bp");
  endtask

  task automatic test_reset_mid_layer();
    start_layer(4'd3, 4'd1, 8'd4, 8'd4);
    run_layer(0, 0, 1'b0, 1'b0, 2);
    checks++;
    if (n_cs != 2 || timed_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_reach_comp: cs=%0d timeout=%0d, required 2 0", n_cs, timed_out);
    end
    rst = 1'b1;
    clear_resp();
    tick();
    checks++;
    if ({busy, bus.rd_req, bus.wr_req, bus.compute_start, seq_done, err_cfg,
         bus.rd_addr, bus.rd_len, bus.wr_addr, bus.wr_len} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: busy=%b rd_req=%b wr_req=%b cs=%b seq=%b, required all 0",
               busy, bus.rd_req, bus.wr_req, bus.compute_start, seq_done);
    end
    rst = 1'b0;
    start_layer(4'd3, 4'd1, 8'd4, 8'd4);
    run_layer(0, 0, 1'b0, 1'b0, 0);
    check_4x4_run("after_rst");
  endtask

  initial begin
    clear_resp();
    test_reset();
    test_basic_4x4();
    test_stride2_5x5();
    test_bad_cfg(4'd0, "bad_k0");
    test_bad_cfg(4'd5, "bad_k5");
    test_backpressure();
    test_reset_mid_layer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
